// File: rtl/sbox_arbiter.sv
// sbox_arbiter: shares one 128-bit S-box array between the round datapath (full state) and key expansion (SubWord).
module sbox_arbiter #(
  parameter bit KEY_PRIORITY = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid_i,
  output logic         a_ready_o,
  input  logic [127:0] a_data_i,
  output logic [127:0] a_result_o,
  output logic         a_done_o,
  input  logic         k_valid_i,
  output logic         k_ready_o,
  input  logic [31:0]  k_word_i,
  output logic [31:0]  k_result_o,
  output logic         k_done_o,
  output logic [127:0] sbox_in_o,
  input  logic [127:0] sbox_out_i
);
  // last_q and s1_owner_q: 1 = key requester, 0 = state requester
  logic         last_q, last_d;
  logic         s1_valid_q, s1_owner_q;
  logic [127:0] sbox_in_q, sbox_in_d;
  logic [127:0] a_result_q, a_result_d;
  logic [31:0]  k_result_q, k_result_d;
  logic         a_done_q, k_done_q;
  logic         a_gnt, k_gnt, hs;
  always_comb begin
    k_gnt      = k_valid_i & ~rst & (~a_valid_i | KEY_PRIORITY | ~last_q);
    a_gnt      = a_valid_i & ~rst & ~k_gnt;
    hs         = a_gnt | k_gnt;
    last_d     = hs ? k_gnt : last_q;
    sbox_in_d  = k_gnt ? {96'h0, k_word_i} : a_gnt ? a_data_i : sbox_in_q;
    a_result_d = (s1_valid_q & ~s1_owner_q) ? sbox_out_i : a_result_q;
    k_result_d = (s1_valid_q & s1_owner_q) ? sbox_out_i[31:0] : k_result_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_q     <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_owner_q <= 1'b0;
      sbox_in_q  <= '0;
      a_result_q <= '0;
      k_result_q <= '0;
      a_done_q   <= 1'b0;
      k_done_q   <= 1'b0;
    end else begin
      last_q     <= last_d;
      s1_valid_q <= hs;
      s1_owner_q <= k_gnt;
      sbox_in_q  <= sbox_in_d;
      a_result_q <= a_result_d;
      k_result_q <= k_result_d;
      a_done_q   <= s1_valid_q & ~s1_owner_q;
      k_done_q   <= s1_valid_q & s1_owner_q;
    end
  assign a_ready_o  = a_gnt;
  assign k_ready_o  = k_gnt;
  assign sbox_in_o  = sbox_in_q;
  assign a_result_o = a_result_q;
  assign k_result_o = k_result_q;
  assign a_done_o   = a_done_q;
  assign k_done_o   = k_done_q;
endmodule

// File: doc/sbox_arbiter.md
# sbox_arbiter

Shares one 16-byte S-box array (SubBytes datapath, 16 parallel byte S-boxes, combinational) between two requesters: the cipher round datapath, which substitutes the full 128-bit state, and the key-expansion unit, which substitutes one 32-bit word (SubWord). The block arbitrates with valid/ready handshakes, registers the selected operand onto the array input, captures the array output, and returns it to the owner with a one-cycle done pulse. Latency is 2 cycles. Throughput is one operation per cycle.

## Interface
- KEY_PRIORITY, 0: 0 = round-robin between requesters; 1 = key requester always wins ties.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  state requester has an operand.
- a_ready  out  1  state operand accepted this cycle when a_valid & a_ready.
- a_data  in  128  state operand.
- a_result  out  128  substituted state; holds until the next state completion.
- a_done  out  1  one-cycle pulse, a_result updated.
- k_valid  in  1  key requester has a word.
- k_ready  out  1  key word accepted when k_valid & k_ready.
- k_word  in  32  key word.
- k_result  out  32  substituted word; holds until the next key completion.
- k_done  out  1  one-cycle pulse, k_result updated.
- sbox_in  out  128  registered operand to the S-box array.
- sbox_out  in  128  combinational S-box array output.

## Operation
- Grant is combinational from a_valid, k_valid and the round-robin pointer. At most one of a_ready and k_ready is high per cycle. Ready is never high without the matching valid.
  - Only one requester valid: that requester is granted.
  - Both valid, KEY_PRIORITY=1: key is granted.
  - Both valid, KEY_PRIORITY=0: the requester not granted last is granted.
- Pointer `last` records the last granted requester. It updates only on a completed handshake. Reset value = key, so the state requester wins the first tie.
- Requesters must hold valid and data stable until ready. Dropping valid before ready is legal; no grant is recorded in that case.
- Stage 1 (on handshake):
  - s1_valid <= 1; s1_owner <= granted requester.
  - State grant: sbox_in <= a_data.
  - Key grant: sbox_in <= {96'h0, k_word}.
  - No handshake: s1_valid <= 0 and sbox_in holds its value.
- Stage 2 (s1_valid):
  - Owner state: a_result <= sbox_out and a_done <= 1.
  - Owner key: k_result <= sbox_out[31:0] and k_done <= 1.
  - Only the owner's done pulses; done outputs are otherwise 0.
- Back-to-back and interleaved grants pipeline without bubbles. A state op and a key op may complete in consecutive cycles in either order.
- Results are returned in grant order per requester. Neither result register is ever written by the other requester's operation.
- No backpressure on results: requesters must sample on done.

## Timing
- Reset (async assert, synchronous-release usage assumed by the system): s1_valid=0, s1_owner=state, sbox_in=0, a_result=0, k_result=0, a_done=0, k_done=0, last=key.
- a_ready and k_ready are 0 while rst is high.
- Handshake in cycle N:
  - sbox_in valid in cycle N+1.
  - done=1 and result valid in cycle N+2.
- Reset mid-operation: in-flight stage-1 and stage-2 ops are dropped with no done pulse; the requester must reissue.
- With both requesters continuously valid and KEY_PRIORITY=0, grants alternate every cycle: state, key, state, key…
- With KEY_PRIORITY=1 and k_valid held high, the state requester starves. This is by design; the key unit bounds its own request run.
- Critical path: sbox_in register -> S-box array -> result registers; one array delay per cycle.

## Test plan
- Reset, then a_data=128'h0 held valid -> a_ready=1 cycle 0; a_done pulses cycle 2; a_result=128'h6363…63 (16 bytes).
- k_word=32'hCF4F3C09 -> k_done in cycle 2, k_result=32'h8A84EB01; a_done stays 0.
- Both valid continuously, KEY_PRIORITY=0:
  - a_data bytes all 0x53, k_word=32'h01FF0001.
  - Grants alternate state, key, state, key, starting with state.
  - Each a_result=16×0xED; each k_result=32'h7C16637C.
  - Completions alternate with no bubbles.
- KEY_PRIORITY=1, both valid for 4 cycles then k_valid low -> four key grants, then state grant in cycle 4; a_done in cycle 6.
- Assert rst in the cycle after a state handshake -> no a_done ever pulses for that op; all outputs return to reset values; a reissued op completes normally 2 cycles after its handshake.
- Random valid toggling on both ports over 10k cycles vs. reference model:
  - never both readies high;
  - each accepted op produces exactly one done with the correct S-box result;
  - results stay in order per requester.
